bin2rns_seq_conv: RTL
=====================

Name: bin2rns_seq_conv

Overview:
Parametrised, handshaked binary-to-RNS forward converter for the RNS datapath, replacing the fixed 10-bit, fixed-moduli lookup converter. It accepts one signed two's-complement word and computes four residues iteratively, C bits per cycle, using MSB-first Horner reduction. It applies sign correction and flags inputs outside the symmetric dynamic range. It sits at the binary-to-RNS boundary ahead of the residue channels and uses valid/ready on both sides.

Parameters:
W, 10, input word width (signed two's complement), W >= 2
C, 2, input bits consumed per RUN cycle, 1 <= C <= W
M0, 8, modulus of channel 0
M1, 7, modulus of channel 1
M2, 5, modulus of channel 2
M3, 3, modulus of channel 3 (moduli pairwise coprime, each >= 2)
RW, 3, residue width, >= clog2(max(M0..M3))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  in_data valid
in_ready  out  1  converter can accept (high only in IDLE and rst low)
in_data  in  W  signed binary input
out_valid  out  1  residues valid
out_ready  in  1  downstream accepts
res0  out  RW  |x| mod M0 with sign correction, in [0,M0)
res1  out  RW  same for M1
res2  out  RW  same for M2
res3  out  RW  same for M3
ovf  out  1  x outside [-M/2, M/2-1], where M = M0*M1*M2*M3

Behaviour:
- Only one clock and one reset: clk, with rst asynchronous and active-high. While rst is high: state=IDLE, in_ready=0, out_valid=0, res0..res3=0, ovf=0, accumulators=0.
- Reset mid-operation aborts the conversion and discards it. After rst deasserts the block is in IDLE with no pending output.
- NCH = ceil(W/C). The magnitude |x| is held as W-bit unsigned, so -2^(W-1) maps to 2^(W-1). It is zero-extended at the MSB end to NCH*C bits.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch sign, magnitude and ovf; set cnt=NCH-1 and acc_i=0; go to RUN.
- RUN: each cycle, take the next C-bit chunk, MSB first, and update acc_i <= (acc_i*2^C + chunk) mod Mi for all four lanes in parallel. When cnt==0, go to FIX; otherwise decrement cnt.
- The reduction result must be exact for any acc_i < Mi and chunk < 2^C. Use a constant-modulus operator or a bounded conditional-subtract chain; no LUT sized by W.
- FIX (1 cycle): res_i <= (neg && acc_i!=0) ? Mi-acc_i : acc_i. Register ovf. Go to DONE.
- DONE: out_valid=1. res0..res3 and ovf are stable while out_valid && !out_ready. On out_ready, go to IDLE with out_valid=0 next cycle.
- There is no same-cycle accept in DONE. Throughput is one conversion per NCH+3 cycles minimum.
- Latency: out_valid rises exactly NCH+1 cycles after the accept edge. With defaults that is 6.
- Range check: ovf=1 iff x < -(M/2) or x > ceil(M/2)-1. Residues are still those of the true x. When M >= 2^W, ovf is constant 0.
- in_data is sampled only on the accept edge; later changes are ignored.
- in_valid while not in IDLE is not accepted; upstream must hold its value.
- Residues always satisfy 0 <= res_i < Mi.

Decomposition:
- Shared package/include holds:
  - clog2 constant function
  - default moduli constants and the derived dynamic-range constant M
  - FSM state encodings (IDLE/RUN/FIX/DONE, 2-bit)
- One sub-module, rns_horner_lane, parametrised by (MOD, C, RW):
  - holds one accumulator
  - ports: clk, rst, clear, step, chunk[C-1:0], neg, acc/corrected-residue output
  - instantiated four times by the top, which owns the FSM, counter, magnitude shift register, range check and handshakes.

Test Plan:
- Defaults, x=419 accepted -> out_valid 6 cycles later; res=(3,6,4,2), ovf=0. x=0 -> (0,0,0,0), ovf=0.
- x=-1 -> (7,6,4,2), ovf=0. x=-420 -> (4,0,0,0), ovf=0 (negation of zero residues gives 0, not Mi).
- x=420 -> (4,0,0,0), ovf=1. x=-421 -> (3,6,4,2), ovf=1. x=-512 (min) -> (0,6,3,1), ovf=1.
- Backpressure: x=100 with out_ready low for 3 cycles after out_valid -> (4,2,0,1) held stable with out_valid high. Accept occurs only on the out_ready cycle. in_ready stays 0 until the block is back in IDLE.
- Reset: assert rst during the 3rd RUN cycle of x=419 -> outputs 0 immediately (asynchronous). After release, a new x=-1 yields (7,6,4,2) with no stale result.
- Exhaustive sweep x=-512..511 with random valid/ready gaps, repeated for C=1, C=3 and W=12 -> every result matches a reference model (x mod Mi, floored, and the ovf rule).

Source files
------------

// File: rtl/bin2rns_seq_conv_pkg.sv
// Shared constants, helper function and FSM encoding for the sequential
// binary-to-RNS forward converter.
package bin2rns_seq_conv_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int M0_DEF = 8;
  localparam int M1_DEF = 7;
  localparam int M2_DEF = 5;
  localparam int M3_DEF = 3;
  localparam int M_DEF  = M0_DEF * M1_DEF * M2_DEF * M3_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rns_horner_lane.sv
// One residue lane: MSB-first Horner accumulator modulo MOD, C bits per step,
// with a combinational sign-corrected view of the accumulator.
module rns_horner_lane
  import bin2rns_seq_conv_pkg::*;
#(
  parameter int MOD = 8,
  parameter int C   = 2,
  parameter int RW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  logic [C-1:0]  chunk,
  input  logic          neg,
  output logic [RW-1:0] res
);

  logic [RW-1:0]   acc;
  logic [RW+C-1:0] shifted;

  // acc < MOD, so {acc, chunk} < MOD*2^C and a single constant modulo is exact.
  assign shifted = {acc, chunk};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= RW'(shifted % (RW+C)'(MOD));
    end
  end

  // When MOD == 2^RW the constant truncates to 0 and the subtraction wraps to MOD-acc.
  assign res = (neg && acc != '0) ? (RW'(MOD) - acc) : acc;

endmodule

// File: rtl/bin2rns_seq_conv.sv
// Handshaked signed binary-to-RNS converter: magnitude is fed C bits per cycle
// into four Horner lanes, then sign-corrected and range-checked.
module bin2rns_seq_conv
  import bin2rns_seq_conv_pkg::*;
#(
  parameter int W  = 10,
  parameter int C  = 2,
  parameter int M0 = M0_DEF,
  parameter int M1 = M1_DEF,
  parameter int M2 = M2_DEF,
  parameter int M3 = M3_DEF,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] res0,
  output logic [RW-1:0] res1,
  output logic [RW-1:0] res2,
  output logic [RW-1:0] res3,
  output logic          ovf
);

  localparam int     NCH  = (W + C - 1) / C;
  localparam int     SW   = NCH * C;
  localparam int     CNTW = clog2(NCH + 1);
  localparam int     MODS [4] = '{M0, M1, M2, M3};
  localparam longint MM   = longint'(M0) * longint'(M1) * longint'(M2) * longint'(M3);
  localparam longint LO   = -(MM / 2);
  localparam longint HI   = (MM + 1) / 2 - 1;

  state_t             state;
  logic [CNTW-1:0]    cnt;
  logic [SW-1:0]      mag_sh;
  logic               neg;
  logic               ovf_pend;
  logic [RW-1:0]      res_q [4];
  logic [RW-1:0]      lane_res [4];
  logic               accept;
  logic [W-1:0]       mag_in;
  logic signed [63:0] x_ext;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  // Unsigned negation maps -2^(W-1) onto 2^(W-1) as required.
  assign mag_in   = in_data[W-1] ? -in_data : in_data;
  assign x_ext    = {{(64-W){in_data[W-1]}}, in_data};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      rns_horner_lane #(
        .MOD (MODS[gi]),
        .C   (C),
        .RW  (RW)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .step  (state == ST_RUN),
        .chunk (mag_sh[SW-1 -: C]),
        .neg   (neg),
        .res   (lane_res[gi])
      );
    end
  endgenerate

  // When MM >= 2^W the bounds enclose every representable input, so ovf stays 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mag_sh    <= '0;
      neg       <= 1'b0;
      ovf_pend  <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      res_q     <= '{default: '0};
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            neg      <= in_data[W-1];
            mag_sh   <= SW'(mag_in);
            ovf_pend <= (x_ext < LO) || (x_ext > HI);
            cnt      <= CNTW'(NCH - 1);
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          mag_sh <= mag_sh << C;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          res_q     <= lane_res;
          ovf       <= ovf_pend;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign res0 = res_q[0];
  assign res1 = res_q[1];
  assign res2 = res_q[2];
  assign res3 = res_q[3];

endmodule
